// File: rtl/stream_mux_rr_if.sv
// Stream bus for the registered N-channel multiplexer: N producer channels
// in, one consumer stream out, plus the mode/select controls.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    // Producer/consumer side: drives the inputs and the output ready.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Multiplexer side.
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N-channel stream multiplexer with valid/ready on every port.
// Fixed-select or round-robin arbitration feeds a single output register,
// giving one-cycle latency and one word per cycle throughput.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int PAD_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic [SEL_W-1:0] outCh_q, outCh_d;
    logic             outValid_q, outValid_d;

    logic             loadEn;
    logic             grantValid;
    logic [SEL_W-1:0] grantIdx;
    logic             transfer;
    logic [WIDTH-1:0] grantData;
    logic [N_CH-1:0]  inReady;

    logic [PAD_W-1:0] validPad;
    logic             fixFound;
    logic             rrFound;
    logic [SEL_W-1:0] rrIdx;
    int               candSum;
    logic [SEL_W-1:0] candIdx;

    // Candidate grants for both modes; valid bits are zero-padded to a power
    // of two so an out-of-range select or candidate simply reads as not valid.
    // The round-robin scan runs from the farthest offset down so the channel
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        validPad = '0;
        validPad[N_CH-1:0] = bus.in_valid;
        fixFound = (int'(bus.sel) < N_CH) && validPad[bus.sel];
        rrFound  = 1'b0;
        rrIdx    = '0;
        candSum  = 0;
        candIdx  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            candSum = int'(ptr_q) + k;
            if (candSum >= N_CH) begin
                candSum = candSum - N_CH;
            end
            candIdx = candSum[SEL_W-1:0];
            if (validPad[candIdx]) begin
                rrFound = 1'b1;
                rrIdx   = candIdx;
            end
        end
    end

    // Pick the active grant, decide whether a word moves this cycle, and
    // steer the granted channel's data and ready.
    always_comb begin
        loadEn = !outValid_q || bus.out_ready;
        if (bus.mode) begin
            grantValid = rrFound;
            grantIdx   = rrIdx;
        end else begin
            grantValid = fixFound;
            grantIdx   = bus.sel;
        end
        transfer  = loadEn && grantValid && !rst;
        grantData = '0;
        inReady   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grantIdx == SEL_W'(i)) begin
                grantData  = bus.in_data[i*WIDTH +: WIDTH];
                inReady[i] = transfer;
            end
        end
    end

    // Next state of the output register and the round-robin pointer; the
    // pointer wraps at N_CH rather than at the select field's natural width.
    always_comb begin
        ptr_d      = ptr_q;
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        if (transfer) begin
            outData_d  = grantData;
            outCh_d    = grantIdx;
            outValid_d = 1'b1;
            ptr_d      = (grantIdx == LAST_CH) ? '0 : grantIdx + SEL_W'(1);
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_data  = outData_q;
    assign bus.out_ch    = outCh_q;
    assign bus.out_valid = outValid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: scenario tasks with inline checks plus a
// negedge scoreboard that predicts grants and every word leaving the mux.
module tb_stream_mux_rr;
    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = $clog2(N_CH);

    logic clk;
    logic rst;
    logic [WIDTH-1:0] chData [N_CH];

    int nChecks = 0;
    int nErrors = 0;

    stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_pack
        assign bus.in_data[gi*WIDTH +: WIDTH] = chData[gi];
    end

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: expected output register contents as a queue.
    logic [SEL_W+WIDTH-1:0] sbQueue [$];
    int                     mPtr = 0;
    logic                   mOutValid = 1'b0;

    // Scoreboard: predict the grant from the model pointer, check ready and
    // the output word, then advance the model as the next rising edge will.
    always @(negedge clk) begin : scoreboard
        int                     g;
        int                     c;
        logic                   mLoad;
        logic [N_CH-1:0]        expReady;
        logic [SEL_W-1:0]       gIdx;
        logic [SEL_W+WIDTH-1:0] front;
        g = -1;
        c = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N_CH && bus.in_valid[bus.sel]) g = int'(bus.sel);
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                c = (mPtr + k) % N_CH;
                if (g < 0 && bus.in_valid[c[SEL_W-1:0]]) g = c;
            end
        end
        mLoad = !mOutValid || bus.out_ready;
        expReady = '0;
        gIdx = '0;
        if (g >= 0) gIdx = g[SEL_W-1:0];
        if (!rst && mLoad && g >= 0) expReady[gIdx] = 1'b1;

        nChecks++;
        if (bus.in_ready !== expReady) begin
            nErrors++;
            $display("[TB] FAIL sb_in_ready got=%b exp=%b t=%0t", bus.in_ready, expReady, $time);
        end
        nChecks++;
        if (bus.out_valid !== mOutValid) begin
            nErrors++;
            $display("[TB] FAIL sb_out_valid got=%b exp=%b t=%0t", bus.out_valid, mOutValid, $time);
        end
        if (mOutValid) begin
            nChecks++;
            if (sbQueue.size() == 0) begin
                nErrors++;
                $display("[TB] FAIL sb_underflow got=empty exp=word t=%0t", $time);
            end else begin
                front = sbQueue[0];
                if ({bus.out_ch, bus.out_data} !== front) begin
                    nErrors++;
                    $display("[TB] FAIL sb_word got=ch%0d/%h exp=ch%0d/%h t=%0t",
                             bus.out_ch, bus.out_data, front[SEL_W+WIDTH-1:WIDTH],
                             front[WIDTH-1:0], $time);
                end
                if (bus.out_ready) void'(sbQueue.pop_front());
            end
        end

        if (rst) begin
            sbQueue.delete();
            mOutValid = 1'b0;
            mPtr = 0;
        end else if (mLoad && g >= 0) begin
            sbQueue.push_back({gIdx, chData[gIdx]});
            mOutValid = 1'b1;
            mPtr = (g + 1) % N_CH;
        end else if (bus.out_ready) begin
            mOutValid = 1'b0;
        end
    end

    // Advance to just after the next rising edge, where inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after the falling edge, where outputs are sampled.
    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    // One-cycle reset pulse used to start scenarios from a known pointer.
    task automatic pulseReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 1'b1;
        bus.sel = '0;
        bus.in_valid = '1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < N_CH; k++) chData[k] = WIDTH'(16 * (k + 1));
        repeat (2) begin
            probe();
            nChecks++;
            if (bus.in_ready !== 4'b0000) begin
                nErrors++; $display("[TB] FAIL reset_in_ready got=%b exp=0000", bus.in_ready);
            end
            nChecks++;
            if (bus.out_valid !== 1'b0) begin
                nErrors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid);
            end
            nChecks++;
            if (bus.out_data !== 8'h00 || bus.out_ch !== 2'd0) begin
                nErrors++; $display("[TB] FAIL reset_out_word got=ch%0d/%h exp=ch0/00", bus.out_ch, bus.out_data);
            end
            tick();
        end
        rst = 1'b0;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b0001) begin
            nErrors++; $display("[TB] FAIL reset_first_grant got=%b exp=0001", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_fixed_mode();
        bus.mode = 1'b0;
        bus.sel = 2'd2;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            probe();
            nChecks++;
            if (bus.in_ready !== 4'b0100) begin
                nErrors++; $display("[TB] FAIL fixed_in_ready got=%b exp=0100", bus.in_ready);
            end
            if (i > 0) begin
                nChecks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h30 || bus.out_ch !== 2'd2) begin
                    nErrors++;
                    $display("[TB] FAIL fixed_out got=v%b ch%0d/%h exp=v1 ch2/30",
                             bus.out_valid, bus.out_ch, bus.out_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [N_CH-1:0] expReady;
        logic [WIDTH-1:0] expData;
        bus.mode = 1'b1;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        pulseReset();
        for (int i = 0; i < 8; i++) begin
            probe();
            if (i > 0) begin
                expData = WIDTH'(16 * (((i - 1) % N_CH) + 1));
                nChecks++;
                if (int'(bus.out_ch) != (i - 1) % N_CH || bus.out_data !== expData) begin
                    nErrors++;
                    $display("[TB] FAIL rr_seq got=ch%0d/%h exp=ch%0d/%h",
                             bus.out_ch, bus.out_data, (i - 1) % N_CH, expData);
                end
            end
            expReady = '0;
            expReady[i % N_CH] = 1'b1;
            nChecks++;
            if (bus.in_ready !== expReady) begin
                nErrors++; $display("[TB] FAIL rr_in_ready got=%b exp=%b", bus.in_ready, expReady);
            end
            tick();
        end
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            probe();
            expReady = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            nChecks++;
            if (bus.in_ready !== expReady) begin
                nErrors++; $display("[TB] FAIL rr_sparse got=%b exp=%b", bus.in_ready, expReady);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b0000;
        pulseReset();
        chData[0] = 8'hA5;
        chData[1] = 8'h5A;
        bus.in_valid = 4'b0001;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b0001) begin
            nErrors++; $display("[TB] FAIL bp_first got=%b exp=0001", bus.in_ready);
        end
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b1110;
        repeat (3) begin
            probe();
            nChecks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_ch !== 2'd0) begin
                nErrors++;
                $display("[TB] FAIL bp_hold got=v%b ch%0d/%h exp=v1 ch0/a5",
                         bus.out_valid, bus.out_ch, bus.out_data);
            end
            nChecks++;
            if (bus.in_ready !== 4'b0000) begin
                nErrors++; $display("[TB] FAIL bp_stall got=%b exp=0000", bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b0010 || bus.out_data !== 8'hA5) begin
            nErrors++;
            $display("[TB] FAIL bp_release got=%b/%h exp=0010/a5", bus.in_ready, bus.out_data);
        end
        tick();
        bus.in_valid = 4'b0000;
        probe();
        nChecks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.out_ch !== 2'd1) begin
            nErrors++;
            $display("[TB] FAIL bp_no_bubble got=v%b ch%0d/%h exp=v1 ch1/5a",
                     bus.out_valid, bus.out_ch, bus.out_data);
        end
        tick();
    endtask

    task automatic test_sparse_wrap();
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b0000;
        pulseReset();
        bus.in_valid = 4'b0100;
        tick();
        bus.in_valid = 4'b1000;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b1000) begin
            nErrors++; $display("[TB] FAIL wrap_ch3 got=%b exp=1000", bus.in_ready);
        end
        tick();
        bus.in_valid = 4'b1001;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b0001 || bus.out_ch !== 2'd3) begin
            nErrors++;
            $display("[TB] FAIL wrap_ptr0 got=%b/ch%0d exp=0001/ch3", bus.in_ready, bus.out_ch);
        end
        tick();
        bus.in_valid = 4'b0000;
        probe();
        nChecks++;
        if (bus.out_ch !== 2'd0) begin
            nErrors++; $display("[TB] FAIL wrap_out_ch got=%0d exp=0", bus.out_ch);
        end
        tick();
    endtask

    // Random stimulus honouring the producer rule: a channel that is valid
    // and was not accepted keeps its valid and data.
    task automatic applyStimulus(input logic [N_CH-1:0] accepted);
        for (int i = 0; i < N_CH; i++) begin
            if (!(bus.in_valid[i] && !accepted[i])) begin
                bus.in_valid[i] = ($urandom_range(0, 9) < 6);
                chData[i] = WIDTH'($urandom);
            end
        end
        if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
        bus.sel = SEL_W'($urandom_range(0, N_CH - 1));
        bus.out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic test_reset_random();
        logic [N_CH-1:0] accepted;
        bus.mode = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b0010;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b0010) begin
            nErrors++; $display("[TB] FAIL mid_load got=%b exp=0010", bus.in_ready);
        end
        tick();
        bus.in_valid = 4'b1111;
        rst = 1'b1;
        probe();
        nChecks++;
        if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL mid_rst_cycle got=%b/v%b exp=0000/v1", bus.in_ready, bus.out_valid);
        end
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        probe();
        nChecks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0001) begin
            nErrors++;
            $display("[TB] FAIL mid_rst_after got=v%b/%b exp=v0/0001", bus.out_valid, bus.in_ready);
        end
        tick();
        accepted = '0;
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(accepted);
            probe();
            accepted = bus.in_ready & bus.in_valid;
            tick();
        end
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        probe();
        nChecks++;
        if (sbQueue.size() != 0 || bus.out_valid !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL drain got=%0d/v%b exp=0/v0", sbQueue.size(), bus.out_valid);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_fixed_mode();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_reset_random();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
